// File: rtl/rpn_pkg.sv
// Types and constants shared along the RPN input path: the digit encoder,
// the ASCII decode stage and digits_to_word.
package rpn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_e;

  localparam int                 DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/digits_to_word_bcd_mac_step.sv
// One radix-10 multiply-accumulate step: acc*10 + din, saturating at 2^WIDTH-1.
// A digit above 9 is flagged and leaves acc untouched.
module bcd_mac_step
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   acc,
  input  logic [DIGIT_W-1:0] din,
  output logic [WIDTH-1:0]   acc_next_sat,
  output logic               ovf,
  output logic               bad
);

  localparam int XW = WIDTH + 4;

  logic [XW-1:0] acc_x;
  logic [XW-1:0] prod;
  logic [XW-1:0] sum;

  // x10 as shift-and-add; WIDTH+4 bits holds (2^WIDTH-1)*10+15 without wrap
  assign acc_x = XW'(acc);
  assign prod  = (acc_x << 3) + (acc_x << 1);
  assign sum   = prod + XW'(din);

  always_comb begin
    bad          = (din > BCD_MAX);
    ovf          = 1'b0;
    acc_next_sat = acc;
    if (!bad) begin
      if (sum > XW'({WIDTH{1'b1}})) begin
        ovf          = 1'b1;
        acc_next_sat = '1;
      end else begin
        acc_next_sat = sum[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/digits_to_word.sv
// Accumulates an MSD-first BCD digit stream into an unsigned binary word,
// one result per group with sticky overflow / bad-digit flags.
module digits_to_word
  import rpn_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] din,
  input  logic               din_valid,
  input  logic               din_last,
  output logic               din_ready,
  input  logic               clear,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_valid,
  output logic               err_ovf,
  output logic               err_digit
);

  // counter saturates one past the limit so a long group never wraps back in range
  localparam int            CW      = $clog2(MAX_DIGITS + 2);
  localparam logic [CW-1:0] CNT_LIM = CW'(MAX_DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             bad_q, bad_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_digit_q, err_digit_d;

  logic [WIDTH-1:0] step_acc;
  logic             step_ovf, step_bad;
  logic [CW-1:0]    cnt_new;
  logic             cnt_ovf;
  logic [WIDTH-1:0] acc_upd;
  logic             dig_ovf;
  logic             accept;

  bcd_mac_step #(.WIDTH(WIDTH)) u_step (
    .acc          (acc_q),
    .din          (din),
    .acc_next_sat (step_acc),
    .ovf          (step_ovf),
    .bad          (step_bad)
  );

  assign din_ready  = (state_q != OUT);
  assign dout_valid = (state_q == OUT);
  assign dout       = dout_q;
  assign err_ovf    = err_ovf_q;
  assign err_digit  = err_digit_q;

  assign accept  = din_valid && din_ready && !clear;
  assign cnt_new = (cnt_q == CNT_LIM) ? cnt_q : cnt_q + CW'(1);
  assign cnt_ovf = (cnt_new > CNT_MAX);
  assign acc_upd = cnt_ovf ? acc_q : step_acc;
  assign dig_ovf = step_ovf || cnt_ovf;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    bad_d       = bad_q;
    dout_d      = dout_q;
    err_ovf_d   = err_ovf_q;
    err_digit_d = err_digit_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (clear) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          bad_d   = 1'b0;
        end else if (accept) begin
          acc_d = acc_upd;
          cnt_d = cnt_new;
          ovf_d = ovf_q || dig_ovf;
          bad_d = bad_q || step_bad;
          if (din_last) begin
            state_d     = OUT;
            dout_d      = acc_upd;
            err_ovf_d   = ovf_q || dig_ovf;
            err_digit_d = bad_q || step_bad;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      OUT: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        bad_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      bad_q       <= 1'b0;
      dout_q      <= '0;
      err_ovf_q   <= 1'b0;
      err_digit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      bad_q       <= bad_d;
      dout_q      <= dout_d;
      err_ovf_q   <= err_ovf_d;
      err_digit_q <= err_digit_d;
    end
  end

endmodule

// File: tb/tb_digits_to_word.sv
// Directed scoreboard bench for digits_to_word (WIDTH=16, MAX_DIGITS=6).
module tb_digits_to_word;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        din_last = 1'b0;
  logic        din_ready;
  logic        clear = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        err_ovf;
  logic        err_digit;

  typedef struct packed {
    logic [15:0] d;
    logic        eo;
    logic        ed;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   pushed = 0;
  int   pulses = 0;

  digits_to_word #(.WIDTH(16), .MAX_DIGITS(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_last   (din_last),
    .din_ready  (din_ready),
    .clear      (clear),
    .dout       (dout),
    .dout_valid (dout_valid),
    .err_ovf    (err_ovf),
    .err_digit  (err_digit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_res(input logic [15:0] d, input logic eo, input logic ed);
    exp_t e;
    e.d = d; e.eo = eo; e.ed = ed;
    sb.push_back(e);
    pushed++;
  endtask

  // drive a digit at negedge, hold until accepted on a posedge
  task automatic send(input logic [3:0] d, input logic last, output int waits);
    waits = 0;
    @(negedge clk);
    din = d; din_valid = 1'b1; din_last = last;
    while (!din_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 20) chk("send_timeout", 32'(waits), 32'd0);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    din_valid = 1'b0; din_last = 1'b0; din = '0;
  endtask

  // scoreboard pop on every result pulse
  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      exp_t e;
      pulses++;
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(dout), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("dout", 32'(dout), 32'(e.d));
        chk("err_ovf", 32'(err_ovf), 32'(e.eo));
        chk("err_digit", 32'(err_digit), 32'(e.ed));
      end
    end
  end

  initial begin
    int w;
    int p;
    #3;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_err_ovf", 32'(err_ovf), 0);
    chk("rst_err_digit", 32'(err_digit), 0);
    chk("rst_din_ready", 32'(din_ready), 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 123 back-to-back, din_ready low exactly in the OUT cycle
    expect_res(16'd123, 1'b0, 1'b0);
    send(4'd1, 1'b0, w); chk("b2b_w1", 32'(w), 0);
    send(4'd2, 1'b0, w); chk("b2b_w2", 32'(w), 0);
    send(4'd3, 1'b1, w);
    idle();
    chk("out_ready", 32'(din_ready), 0);
    chk("out_valid", 32'(dout_valid), 1);
    @(negedge clk);
    chk("post_ready", 32'(din_ready), 1);
    chk("post_valid", 32'(dout_valid), 0);
    chk("hold_dout", 32'(dout), 123);

    // six digits with leading zero hits the maximum exactly
    expect_res(16'd65535, 1'b0, 1'b0);
    send(4'd0, 1'b0, w); send(4'd6, 1'b0, w); send(4'd5, 1'b0, w);
    send(4'd5, 1'b0, w); send(4'd3, 1'b0, w); send(4'd5, 1'b1, w);
    idle();

    // 65536 saturates
    expect_res(16'd65535, 1'b1, 1'b0);
    send(4'd6, 1'b0, w); send(4'd5, 1'b0, w); send(4'd5, 1'b0, w);
    send(4'd3, 1'b0, w); send(4'd6, 1'b1, w);
    idle();

    // seven digits exceed MAX_DIGITS
    expect_res(16'd0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) send(4'd0, 1'b0, w);
    send(4'd7, 1'b1, w);
    idle();

    // bad digit contributes nothing
    expect_res(16'd42, 1'b0, 1'b1);
    send(4'd4, 1'b0, w); send(4'hA, 1'b0, w); send(4'd2, 1'b1, w);
    idle();
    @(negedge clk);

    // clear in mid-group, outputs held
    send(4'd9, 1'b0, w); send(4'd9, 1'b0, w);
    @(negedge clk);
    din_valid = 1'b0; din_last = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_hold_dout", 32'(dout), 42);
    chk("clr_hold_edig", 32'(err_digit), 1);
    chk("clr_no_valid", 32'(dout_valid), 0);
    expect_res(16'd5, 1'b0, 1'b0);
    send(4'd5, 1'b1, w);
    idle();
    @(negedge clk);

    // clear with a valid last digit drops it
    p = pulses;
    din = 4'd3; din_valid = 1'b1; din_last = 1'b1; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; din_valid = 1'b0; din_last = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("clr_drop_pulses", 32'(pulses), 32'(p));
    chk("clr_drop_ready", 32'(din_ready), 1);
    expect_res(16'd6, 1'b0, 1'b0);
    send(4'd6, 1'b1, w);
    idle();
    @(negedge clk);

    // digit presented during OUT waits one cycle
    expect_res(16'd7, 1'b0, 1'b0);
    expect_res(16'd8, 1'b0, 1'b0);
    send(4'd7, 1'b1, w);
    send(4'd8, 1'b1, w);
    chk("out_stall_waits", 32'(w), 1);
    idle();
    @(negedge clk);

    // async reset mid-group
    send(4'd3, 1'b0, w); send(4'd4, 1'b0, w);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout", 32'(dout), 0);
    chk("arst_valid", 32'(dout_valid), 0);
    chk("arst_eovf", 32'(err_ovf), 0);
    chk("arst_edig", 32'(err_digit), 0);
    chk("arst_ready", 32'(din_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    expect_res(16'd2, 1'b0, 1'b0);
    send(4'd2, 1'b1, w);
    idle();

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    chk("pulse_count", 32'(pulses), 32'(pushed));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/digits_to_word.md
Name: digits_to_word

Overview:
- Inverse of the binary-to-decimal streamer: accepts a serial stream of BCD digits, MSD first, and accumulates it into an unsigned binary word.
- Sits on the RPN input path between the UART RX / ASCII-digit decode stage and the operand stack.
- Emits one result word per digit group, plus error flags for overflow, bad digits and over-long groups.

Parameters:
- WIDTH, 16, width of the result word; the maximum representable value is 2^WIDTH-1.
- MAX_DIGITS, 6, maximum digits accepted per group, counting leading zeros. It must be at least ceil(log10(2^WIDTH)), and it matches the 6-digit output of the encoder.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- din  input  4  BCD digit, MSD first
- din_valid  input  1  din is presented this cycle
- din_last  input  1  qualifies din_valid; this digit ends the group
- din_ready  output  1  block can accept a digit this cycle
- clear  input  1  synchronous abort of the group in progress
- dout  output  WIDTH  converted value; held until the next result
- dout_valid  output  1  one-cycle pulse when dout is updated
- err_ovf  output  1  last result overflowed or exceeded MAX_DIGITS; held with dout
- err_digit  output  1  last result contained a digit greater than 9; held with dout

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset values:
  - dout, dout_valid, err_ovf and err_digit are 0.
  - The accumulator, the digit count and the sticky flags are 0.
  - The state is IDLE and din_ready is 1.
- Transfer rule: a digit is accepted when din_valid and din_ready are both 1 on a rising clk edge. Nothing else advances the accumulator.
- States:
  - IDLE: no group in progress.
    - An accepted digit without din_last goes to ACCUM.
    - An accepted digit with din_last goes to OUT, giving a single-digit group.
  - ACCUM: group in progress.
    - An accepted digit without din_last stays in ACCUM.
    - An accepted digit with din_last goes to OUT.
  - OUT: lasts exactly one cycle, then returns to IDLE.
    - din_ready is 0 during OUT.
    - dout_valid is 1 during OUT.
    - The accumulator, the count and the sticky flags are cleared on exit.
- din_ready is combinational and equals (state != OUT).
- Accumulate step, applied to each accepted digit:
  - acc_next = acc*10 + din, computed in WIDTH+4 bits.
  - If acc_next > 2^WIDTH-1, set sticky ovf and keep acc at 2^WIDTH-1 (saturate).
  - If din > 9, set sticky bad and add nothing to acc.
  - Increment the digit count. If the new count is greater than MAX_DIGITS, set sticky ovf and leave acc unchanged.
- Result latency: the result registers load on the edge that accepts the din_last digit, so dout, err_ovf, err_digit and dout_valid are visible in the following cycle (the OUT cycle). The loaded values are:
  - dout: the saturated acc_next.
  - err_ovf: sticky ovf OR that digit's own ovf.
  - err_digit: sticky bad OR that digit's own bad.
- Holding outputs: dout, err_ovf and err_digit hold until the next OUT cycle. They are not cleared on return to IDLE.
- Back-to-back groups: the next group's first digit is accepted in the cycle after OUT. The maximum throughput is therefore one group per (digits + 1) cycles.
- clear:
  - In IDLE or ACCUM: return to IDLE, zero the accumulator, count and sticky flags, produce no dout_valid, and leave dout and the error flags unchanged.
  - When clear and din_valid occur in the same cycle, clear wins and the digit is dropped.
  - In OUT, clear has no effect; the result is still delivered.
- Reset mid-group: the group is discarded and no partial result is output.
- Width rule: the multiply by 10 is implemented as (acc<<3)+(acc<<1) in WIDTH+4 bits. No divider is permitted.

Decomposition:
- Shared package rpn_pkg holds:
  - the state enum (IDLE, ACCUM, OUT);
  - the BCD_MAX constant (9);
  - the DIGIT_W constant (4).
  These are shared with the binary-to-digits encoder and the ASCII decode stage.
- One sub-module is natural: bcd_mac_step. It is combinational and maps acc, din to acc_next_sat, ovf, bad. It is unit-testable on its own and reusable by any future radix-input block.

Test Plan:
- Digits 1,2,3 (last on 3), back-to-back -> one cycle after the 3 is accepted: dout=123, dout_valid for one cycle, err_ovf=0, err_digit=0. din_ready is low for exactly that cycle.
- Digits 0,6,5,5,3,5 (six digits including a leading zero) -> dout=65535, no errors. Then digits 6,5,5,3,6 -> dout=65535, err_ovf=1.
- Digits 0,0,0,0,0,0,7 with last on 7 (seven digits) -> err_ovf=1, dout=0. Digits 4,0xA,2 -> dout=42, err_digit=1.
- Stream 9,9 then clear, then 5 (last) -> a single dout_valid with dout=5. Clear asserted together with a valid digit -> the digit is dropped.
- Groups "7" (last), then "8" presented during the OUT cycle and held -> "8" is accepted only after OUT. The results 7 and 8 appear in order with two dout_valid pulses.
- Drive rst_n low after digits 3,4 -> all outputs 0 immediately, asynchronously. Then digits 2 (last) -> dout=2, with no residue from 34.
